net_interface: RTL and testbench
================================

NET_INTERFACE -- requirements
Module: net_interface

Interface
REQ-001 Parameter DEPTH, default 4, sets the entry count of each FIFO; it SHALL be a power of two, at least 2.
REQ-002 Parameter DEST_W, default 8, sets the width of the router destination field.
REQ-003 Port CLK, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-004 Port RESET, input, 1 bit: asynchronous, active-high reset.
REQ-005 Port NET_WRITE, input, 1 bit: the MEM-stage instruction is SWNET.
REQ-006 Port NET_READ, input, 1 bit: the MEM-stage instruction is LWNET.
REQ-007 Port ADDRESS, input, 32 bits: ALU result; ADDRESS[DEST_W-1:0] is the destination node.
REQ-008 Port WRITE_DATA, input, 32 bits: the SWNET payload, taken from rs2.
REQ-009 Port READ_DATA, output, 32 bits: the LWNET result, routed to writeback select 01.
REQ-010 Port BUSY, output, 1 bit: pipeline stall request.
REQ-011 Port TX_VALID, output, 1 bit: a flit is offered to the router.
REQ-012 Port TX_READY, input, 1 bit: the router accepts the flit.
REQ-013 Port TX_DEST, output, DEST_W bits: destination of the offered flit.
REQ-014 Port TX_DATA, output, 32 bits: payload of the offered flit.
REQ-015 Port RX_VALID, input, 1 bit: the router offers an incoming flit.
REQ-016 Port RX_READY, output, 1 bit: the interface accepts the incoming flit.
REQ-017 Port RX_DATA, input, 32 bits: payload of the incoming flit.
REQ-018 Ports TX_COUNT and RX_COUNT, outputs, log2(DEPTH)+1 bits each: occupancy of each FIFO.

Function
REQ-019 The TX FIFO SHALL hold {dest, data} entries; the RX FIFO SHALL hold 32-bit data entries; both SHALL be first-in first-out.
- Each FIFO SHALL use read and write pointers that wrap modulo DEPTH, plus a count register.
REQ-020 TX push: NET_WRITE=1 with TX not full -> push {ADDRESS[DEST_W-1:0], WRITE_DATA} at the clock edge.
REQ-021 TX pop: TX_VALID=1 and TX_READY=1 -> pop the TX head at the clock edge.
REQ-022 TX_VALID SHALL equal (TX_COUNT != 0); TX_DEST and TX_DATA SHALL present the TX head combinationally.
- Once TX_VALID is asserted, the head SHALL stay stable until it is popped.
REQ-023 RX push: RX_VALID=1 and RX_READY=1 -> push RX_DATA at the clock edge.
- RX_READY SHALL equal (RX_COUNT != DEPTH).
REQ-024 RX pop: NET_READ=1 with RX not empty -> pop the RX head at the clock edge.
- READ_DATA SHALL show the RX head combinationally in the same cycle as the pop.
- READ_DATA SHALL be 32'h0 whenever RX is empty.
REQ-025 BUSY SHALL equal (NET_WRITE & TX full) | (NET_READ & RX empty), purely combinational.
- No push or pop SHALL occur for an operation that is stalled.
REQ-026 Full TX: a push SHALL be blocked even if TX_READY=1 in the same cycle (no bypass), so BUSY never depends on TX_READY.
- The stalled SWNET SHALL complete in the cycle after the pop.
REQ-027 Empty RX: there SHALL be no fall-through; an LWNET stalled on empty RX SHALL complete one cycle after the RX push.
REQ-028 A simultaneous push and pop on the same FIFO SHALL leave its count unchanged, and both SHALL be performed.
REQ-029 NET_WRITE and NET_READ asserted together SHALL be serviced independently, with BUSY as the OR of both stall terms.
REQ-030 Latency: an SWNET entering an empty TX FIFO SHALL raise TX_VALID exactly one cycle later.

Reset
REQ-031 While RESET=1, asynchronously:
- all pointers and counts SHALL be 0;
- TX_VALID SHALL be 0, TX_DEST and TX_DATA 0, READ_DATA 0, BUSY per REQ-025;
- RX_READY SHALL be 1.
REQ-032 A reset mid-transfer SHALL discard all buffered flits; no flit SHALL be emitted twice after release.

Verification
REQ-033 Single send: NET_WRITE=1, ADDRESS=32'h0000_0005, WRITE_DATA=32'hDEAD_BEEF with TX_READY=1 -> next cycle TX_VALID=1, TX_DEST=8'h05, TX_DATA=32'hDEAD_BEEF; the cycle after, TX_VALID=0.
REQ-034 TX full: TX_READY=0 and 5 SWNETs with data 1..5 -> BUSY=1 on the 5th; raise TX_READY -> data 1,2,3,4,5 emitted in order, with BUSY low after the first pop.
REQ-035 RX stall: NET_READ=1 with RX empty -> BUSY=1, READ_DATA=0; then RX_VALID=1, RX_DATA=32'h0000_00A5 -> next cycle BUSY=0, READ_DATA=32'h0000_00A5, RX_COUNT goes 1->0.
REQ-036 RX full: 4 flits pushed with no reads -> RX_READY=0 and a 5th offered flit is held off; one LWNET -> RX_READY=1 next cycle.
REQ-037 Pointer wrap: 10 interleaved push/pop pairs on each FIFO -> data order is preserved across wrap-around and counts never exceed DEPTH.
REQ-038 Reset mid-operation: RESET pulsed with TX_COUNT=3 -> TX_VALID=0 and counts=0 immediately, with no clock edge required.

Source files
------------

// File: rtl/net_interface_if.sv
// Core-side and router-side signals of the network interface.
// The slave modport is the interface block; master is the core/router side.
interface net_interface_if #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned DEST_W = 8
);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic              NET_WRITE;
    logic              NET_READ;
    logic [31:0]       ADDRESS;
    logic [31:0]       WRITE_DATA;
    logic [31:0]       READ_DATA;
    logic              BUSY;
    logic              TX_VALID;
    logic              TX_READY;
    logic [DEST_W-1:0] TX_DEST;
    logic [31:0]       TX_DATA;
    logic              RX_VALID;
    logic              RX_READY;
    logic [31:0]       RX_DATA;
    logic [CNT_W-1:0]  TX_COUNT;
    logic [CNT_W-1:0]  RX_COUNT;

    modport slave (
        input  NET_WRITE, NET_READ, ADDRESS, WRITE_DATA, TX_READY, RX_VALID, RX_DATA,
        output READ_DATA, BUSY, TX_VALID, TX_DEST, TX_DATA, RX_READY, TX_COUNT, RX_COUNT
    );

    modport master (
        output NET_WRITE, NET_READ, ADDRESS, WRITE_DATA, TX_READY, RX_VALID, RX_DATA,
        input  READ_DATA, BUSY, TX_VALID, TX_DEST, TX_DATA, RX_READY, TX_COUNT, RX_COUNT
    );
endinterface

// File: rtl/net_interface.sv
// Network interface between the MEM stage and the router: a TX FIFO fed by
// SWNET and drained by the router, and an RX FIFO fed by the router and drained by LWNET.
module net_interface #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned DEST_W = 8
) (
    input  logic             CLK,
    input  logic             RESET,
    net_interface_if.slave   bus
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [DEST_W-1:0] dest;
        logic [31:0]       data;
    } tx_entry_t;

    tx_entry_t        tx_mem_q [DEPTH];
    tx_entry_t        tx_mem_d [DEPTH];
    logic [31:0]      rx_mem_q [DEPTH];
    logic [31:0]      rx_mem_d [DEPTH];
    logic [PTR_W-1:0] tx_wr_ptr_q, tx_wr_ptr_d, tx_rd_ptr_q, tx_rd_ptr_d;
    logic [PTR_W-1:0] rx_wr_ptr_q, rx_wr_ptr_d, rx_rd_ptr_q, rx_rd_ptr_d;
    logic [CNT_W-1:0] tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;

    logic tx_full_c, tx_empty_c, rx_full_c, rx_empty_c;
    logic tx_push_c, tx_pop_c, rx_push_c, rx_pop_c;

    // Stalled operations never touch the FIFOs; full TX has no bypass path.
    assign tx_full_c  = (tx_cnt_q == CNT_W'(DEPTH));
    assign tx_empty_c = (tx_cnt_q == '0);
    assign rx_full_c  = (rx_cnt_q == CNT_W'(DEPTH));
    assign rx_empty_c = (rx_cnt_q == '0);

    assign tx_push_c = bus.NET_WRITE & ~tx_full_c;
    assign tx_pop_c  = ~tx_empty_c & bus.TX_READY;
    assign rx_push_c = bus.RX_VALID & ~rx_full_c;
    assign rx_pop_c  = bus.NET_READ & ~rx_empty_c;

    assign bus.BUSY      = (bus.NET_WRITE & tx_full_c) | (bus.NET_READ & rx_empty_c);
    assign bus.TX_VALID  = ~tx_empty_c;
    assign bus.TX_DEST   = tx_empty_c ? '0 : tx_mem_q[tx_rd_ptr_q].dest;
    assign bus.TX_DATA   = tx_empty_c ? '0 : tx_mem_q[tx_rd_ptr_q].data;
    assign bus.RX_READY  = ~rx_full_c;
    assign bus.READ_DATA = rx_empty_c ? '0 : rx_mem_q[rx_rd_ptr_q];
    assign bus.TX_COUNT  = tx_cnt_q;
    assign bus.RX_COUNT  = rx_cnt_q;

    // Upper address bits are not part of the destination.
    generate
        if (DEST_W < 32) begin : g_addr_unused
            logic unused_addr_c;
            assign unused_addr_c = ^bus.ADDRESS[31:DEST_W];
        end
    endgenerate

    always_comb begin
        tx_mem_d    = tx_mem_q;
        rx_mem_d    = rx_mem_q;
        tx_wr_ptr_d = tx_wr_ptr_q;
        tx_rd_ptr_d = tx_rd_ptr_q;
        rx_wr_ptr_d = rx_wr_ptr_q;
        rx_rd_ptr_d = rx_rd_ptr_q;
        tx_cnt_d    = tx_cnt_q;
        rx_cnt_d    = rx_cnt_q;

        if (tx_push_c) begin
            tx_mem_d[tx_wr_ptr_q] = '{dest: bus.ADDRESS[DEST_W-1:0], data: bus.WRITE_DATA};
            tx_wr_ptr_d           = tx_wr_ptr_q + PTR_W'(1);
        end
        if (tx_pop_c) begin
            tx_rd_ptr_d = tx_rd_ptr_q + PTR_W'(1);
        end
        case ({tx_push_c, tx_pop_c})
            2'b10:   tx_cnt_d = tx_cnt_q + CNT_W'(1);
            2'b01:   tx_cnt_d = tx_cnt_q - CNT_W'(1);
            default: tx_cnt_d = tx_cnt_q;
        endcase

        if (rx_push_c) begin
            rx_mem_d[rx_wr_ptr_q] = bus.RX_DATA;
            rx_wr_ptr_d           = rx_wr_ptr_q + PTR_W'(1);
        end
        if (rx_pop_c) begin
            rx_rd_ptr_d = rx_rd_ptr_q + PTR_W'(1);
        end
        case ({rx_push_c, rx_pop_c})
            2'b10:   rx_cnt_d = rx_cnt_q + CNT_W'(1);
            2'b01:   rx_cnt_d = rx_cnt_q - CNT_W'(1);
            default: rx_cnt_d = rx_cnt_q;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                tx_mem_q[i] <= '0;
                rx_mem_q[i] <= '0;
            end
            tx_wr_ptr_q <= '0;
            tx_rd_ptr_q <= '0;
            rx_wr_ptr_q <= '0;
            rx_rd_ptr_q <= '0;
            tx_cnt_q    <= '0;
            rx_cnt_q    <= '0;
        end else begin
            tx_mem_q    <= tx_mem_d;
            rx_mem_q    <= rx_mem_d;
            tx_wr_ptr_q <= tx_wr_ptr_d;
            tx_rd_ptr_q <= tx_rd_ptr_d;
            rx_wr_ptr_q <= rx_wr_ptr_d;
            rx_rd_ptr_q <= rx_rd_ptr_d;
            tx_cnt_q    <= tx_cnt_d;
            rx_cnt_q    <= rx_cnt_d;
        end
    end
endmodule

// File: tb/tb_net_interface.sv
// Directed bench for net_interface: a vector table of per-cycle inputs and
// expected combinational outputs, plus hand-written wrap and reset sequences.
module tb_net_interface;
    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    net_interface_if #(.DEPTH(4), .DEST_W(8)) bus ();

    net_interface #(.DEPTH(4), .DEST_W(8)) dut (
        .CLK   (clk),
        .RESET (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] nw, nr, addr, wd, trdy, rvld, rdata;
        logic [31:0] busy, rd, tv, tdest, tdata, rrdy, tc, rc;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic [31:0] nw, nr, addr, wd, trdy, rvld, rdata,
                       input logic [31:0] busy, rd, tv, tdest, tdata, rrdy, tc, rc);
        vec_t v;
        v = '{nw, nr, addr, wd, trdy, rvld, rdata, busy, rd, tv, tdest, tdata, rrdy, tc, rc};
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Inputs change just after the falling edge; outputs are sampled 1ns later.
    task automatic drive(input logic [31:0] nw, nr, addr, wd, trdy, rvld, rdata);
        @(negedge clk);
        bus.NET_WRITE  = nw[0];
        bus.NET_READ   = nr[0];
        bus.ADDRESS    = addr;
        bus.WRITE_DATA = wd;
        bus.TX_READY   = trdy[0];
        bus.RX_VALID   = rvld[0];
        bus.RX_DATA    = rdata;
        #1;
    endtask

    initial begin
        rst            = 1'b1;
        bus.NET_WRITE  = 1'b0;
        bus.NET_READ   = 1'b0;
        bus.ADDRESS    = '0;
        bus.WRITE_DATA = '0;
        bus.TX_READY   = 1'b0;
        bus.RX_VALID   = 1'b0;
        bus.RX_DATA    = '0;
        #1;
        chk("rst_tx_valid", 32'(bus.TX_VALID), 32'd0);
        chk("rst_tx_data", bus.TX_DATA, 32'd0);
        chk("rst_tx_dest", 32'(bus.TX_DEST), 32'd0);
        chk("rst_read_data", bus.READ_DATA, 32'd0);
        chk("rst_rx_ready", 32'(bus.RX_READY), 32'd1);
        chk("rst_tx_count", 32'(bus.TX_COUNT), 32'd0);
        chk("rst_rx_count", 32'(bus.RX_COUNT), 32'd0);
        chk("rst_busy_idle", 32'(bus.BUSY), 32'd0);
        bus.NET_READ = 1'b1;
        #1;
        chk("rst_busy_read", 32'(bus.BUSY), 32'd1);
        bus.NET_READ = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        //   nw nr addr  wd            trdy rvld rdata    busy rd     tv dest data          rrdy tc rc
        add(0, 0, 0,    0,            0,   0,   0,       0,   0,     0, 0,   0,            1,   0, 0);
        add(1, 0, 5,    32'hDEADBEEF, 1,   0,   0,       0,   0,     0, 0,   0,            1,   0, 0);
        add(0, 0, 0,    0,            1,   0,   0,       0,   0,     1, 5,   32'hDEADBEEF, 1,   1, 0);
        add(0, 0, 0,    0,            1,   0,   0,       0,   0,     0, 0,   0,            1,   0, 0);
        add(1, 0, 1,    1,            0,   0,   0,       0,   0,     0, 0,   0,            1,   0, 0);
        add(1, 0, 2,    2,            0,   0,   0,       0,   0,     1, 1,   1,            1,   1, 0);
        add(1, 0, 3,    3,            0,   0,   0,       0,   0,     1, 1,   1,            1,   2, 0);
        add(1, 0, 4,    4,            0,   0,   0,       0,   0,     1, 1,   1,            1,   3, 0);
        add(1, 0, 5,    5,            0,   0,   0,       1,   0,     1, 1,   1,            1,   4, 0);
        add(1, 0, 5,    5,            1,   0,   0,       1,   0,     1, 1,   1,            1,   4, 0);
        add(1, 0, 5,    5,            1,   0,   0,       0,   0,     1, 2,   2,            1,   3, 0);
        add(0, 0, 0,    0,            1,   0,   0,       0,   0,     1, 3,   3,            1,   3, 0);
        add(0, 0, 0,    0,            1,   0,   0,       0,   0,     1, 4,   4,            1,   2, 0);
        add(0, 0, 0,    0,            1,   0,   0,       0,   0,     1, 5,   5,            1,   1, 0);
        add(0, 0, 0,    0,            1,   0,   0,       0,   0,     0, 0,   0,            1,   0, 0);
        add(0, 1, 0,    0,            0,   0,   0,       1,   0,     0, 0,   0,            1,   0, 0);
        add(0, 1, 0,    0,            0,   1,   32'hA5,  1,   0,     0, 0,   0,            1,   0, 0);
        add(0, 1, 0,    0,            0,   0,   0,       0,   32'hA5, 0, 0,  0,            1,   0, 1);
        add(0, 0, 0,    0,            0,   0,   0,       0,   0,     0, 0,   0,            1,   0, 0);
        add(0, 0, 0,    0,            0,   1,   32'h11,  0,   0,     0, 0,   0,            1,   0, 0);
        add(0, 0, 0,    0,            0,   1,   32'h22,  0,   32'h11, 0, 0,  0,            1,   0, 1);
        add(0, 0, 0,    0,            0,   1,   32'h33,  0,   32'h11, 0, 0,  0,            1,   0, 2);
        add(0, 0, 0,    0,            0,   1,   32'h44,  0,   32'h11, 0, 0,  0,            1,   0, 3);
        add(0, 0, 0,    0,            0,   1,   32'h55,  0,   32'h11, 0, 0,  0,            0,   0, 4);
        add(0, 1, 0,    0,            0,   1,   32'h55,  0,   32'h11, 0, 0,  0,            0,   0, 4);
        add(0, 0, 0,    0,            0,   1,   32'h55,  0,   32'h22, 0, 0,  0,            1,   0, 3);
        add(0, 0, 0,    0,            0,   0,   0,       0,   32'h22, 0, 0,  0,            0,   0, 4);
        add(0, 1, 0,    0,            0,   0,   0,       0,   32'h22, 0, 0,  0,            0,   0, 4);
        add(0, 1, 0,    0,            0,   0,   0,       0,   32'h33, 0, 0,  0,            1,   0, 3);
        add(0, 1, 0,    0,            0,   0,   0,       0,   32'h44, 0, 0,  0,            1,   0, 2);
        add(0, 1, 0,    0,            0,   0,   0,       0,   32'h55, 0, 0,  0,            1,   0, 1);
        add(0, 0, 0,    0,            0,   0,   0,       0,   0,     0, 0,   0,            1,   0, 0);
        add(1, 1, 7,    32'h77,       0,   0,   0,       1,   0,     0, 0,   0,            1,   0, 0);
        add(0, 0, 0,    0,            0,   0,   0,       0,   0,     1, 7,   32'h77,       1,   1, 0);
        add(0, 0, 0,    0,            1,   0,   0,       0,   0,     1, 7,   32'h77,       1,   1, 0);
        add(0, 0, 0,    0,            1,   0,   0,       0,   0,     0, 0,   0,            1,   0, 0);

        foreach (vecs[i]) begin
            drive(vecs[i].nw, vecs[i].nr, vecs[i].addr, vecs[i].wd,
                  vecs[i].trdy, vecs[i].rvld, vecs[i].rdata);
            chk($sformatf("v%0d_busy", i),      32'(bus.BUSY),      vecs[i].busy);
            chk($sformatf("v%0d_read_data", i), bus.READ_DATA,      vecs[i].rd);
            chk($sformatf("v%0d_tx_valid", i),  32'(bus.TX_VALID),  vecs[i].tv);
            chk($sformatf("v%0d_tx_dest", i),   32'(bus.TX_DEST),   vecs[i].tdest);
            chk($sformatf("v%0d_tx_data", i),   bus.TX_DATA,        vecs[i].tdata);
            chk($sformatf("v%0d_rx_ready", i),  32'(bus.RX_READY),  vecs[i].rrdy);
            chk($sformatf("v%0d_tx_count", i),  32'(bus.TX_COUNT),  vecs[i].tc);
            chk($sformatf("v%0d_rx_count", i),  32'(bus.RX_COUNT),  vecs[i].rc);
        end

        // TX wrap: one resident entry, then ten simultaneous push/pop cycles.
        drive(1, 0, 9, 200, 0, 0, 0);
        for (int i = 1; i <= 10; i++) begin
            drive(1, 0, 9, 32'(200 + i), 1, 0, 0);
            chk($sformatf("txwrap%0d_data", i),  bus.TX_DATA, 32'(200 + i - 1));
            chk($sformatf("txwrap%0d_count", i), 32'(bus.TX_COUNT), 32'd1);
            chk($sformatf("txwrap%0d_busy", i),  32'(bus.BUSY), 32'd0);
        end
        drive(0, 0, 0, 0, 1, 0, 0);
        chk("txwrap_last", bus.TX_DATA, 32'd210);
        drive(0, 0, 0, 0, 0, 0, 0);
        chk("txwrap_empty", 32'(bus.TX_COUNT), 32'd0);

        // RX wrap: same pattern through the LWNET side.
        drive(0, 0, 0, 0, 0, 1, 300);
        for (int i = 1; i <= 10; i++) begin
            drive(0, 1, 0, 0, 0, 1, 32'(300 + i));
            chk($sformatf("rxwrap%0d_data", i),  bus.READ_DATA, 32'(300 + i - 1));
            chk($sformatf("rxwrap%0d_count", i), 32'(bus.RX_COUNT), 32'd1);
            chk($sformatf("rxwrap%0d_busy", i),  32'(bus.BUSY), 32'd0);
        end
        drive(0, 1, 0, 0, 0, 0, 0);
        chk("rxwrap_last", bus.READ_DATA, 32'd310);
        drive(0, 0, 0, 0, 0, 0, 0);
        chk("rxwrap_empty", 32'(bus.RX_COUNT), 32'd0);

        // Reset with three flits buffered, asserted away from any clock edge.
        drive(1, 0, 3, 32'hA, 0, 1, 32'h66);
        drive(1, 0, 3, 32'hB, 0, 0, 0);
        drive(1, 0, 3, 32'hC, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0);
        chk("pre_reset_tx_count", 32'(bus.TX_COUNT), 32'd3);
        chk("pre_reset_rx_count", 32'(bus.RX_COUNT), 32'd1);
        rst = 1'b1;
        #1;
        chk("midrst_tx_valid", 32'(bus.TX_VALID), 32'd0);
        chk("midrst_tx_count", 32'(bus.TX_COUNT), 32'd0);
        chk("midrst_rx_count", 32'(bus.RX_COUNT), 32'd0);
        chk("midrst_tx_data", bus.TX_DATA, 32'd0);
        chk("midrst_read_data", bus.READ_DATA, 32'd0);
        chk("midrst_rx_ready", 32'(bus.RX_READY), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        drive(0, 0, 0, 0, 1, 0, 0);
        chk("postrst_tx_valid", 32'(bus.TX_VALID), 32'd0);
        drive(0, 0, 0, 0, 1, 0, 0);
        chk("postrst_tx_count", 32'(bus.TX_COUNT), 32'd0);
        chk("postrst_tx_valid2", 32'(bus.TX_VALID), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
